pc_seq_unit: RTL and testbench



---
 rtl/pc_seq_unit_pkg.sv | 22 ++
 rtl/pc_seq_unit_if.sv | 36 +++
 rtl/pc_seq_unit_ras.sv | 47 ++++
 rtl/pc_seq_unit.sv | 127 ++++++++++++
 tb/tb_pc_seq_unit.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_unit_pkg.sv
// pc_pkg: PCSrc encodings, cause codes and FSM states shared by
// the program-counter unit, its return stack and the bench.
package pc_pkg;

  localparam logic [2:0] PCSRC_SEQ  = 3'b000;
  localparam logic [2:0] PCSRC_BR   = 3'b001;
  localparam logic [2:0] PCSRC_REG  = 3'b010;
  localparam logic [2:0] PCSRC_JMP  = 3'b011;
  localparam logic [2:0] PCSRC_ERET = 3'b100;
  localparam logic [2:0] PCSRC_RAS  = 3'b101;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_MISAL = 2'd1;
  localparam logic [1:0] CAUSE_EXT   = 2'd2;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    TRAP = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/pc_seq_unit_if.sv
// pc_seq_unit_if: control-unit <-> PC unit bundle.
// master = control/fetch side, slave = pc_seq_unit.
interface pc_seq_unit_if #(
  parameter int XLEN = 32
);

  logic            PCWre;
  logic [2:0]      PCSrc;
  logic [XLEN-1:0] ImExt;
  logic [25:0]     j_addr;
  logic [XLEN-1:0] ReadData1;
  logic            link;
  logic            exc_req;
  logic            halt_req;
  logic [XLEN-1:0] currentPC;
  logic [XLEN-1:0] nextPC;
  logic [XLEN-1:0] epc;
  logic [1:0]      cause;
  logic            trap;
  logic            halted;

  modport master (
    output PCWre, PCSrc, ImExt, j_addr,
    output ReadData1, link, exc_req, halt_req,
    input  currentPC, nextPC, epc, cause,
    input  trap, halted
  );

  modport slave (
    input  PCWre, PCSrc, ImExt, j_addr,
    input  ReadData1, link, exc_req, halt_req,
    output currentPC, nextPC, epc, cause,
    output trap, halted
  );

endinterface

// File: rtl/pc_seq_unit_ras.sv
// pc_ras: circular return-address stack; a push when full
// overwrites the oldest entry. Ports: CLK, RST, push, pop, din, top, empty.
module pc_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ONE = AW'(1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT1 = (AW+1)'(1);

  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   sp;
  logic [AW:0]     cnt;

  assign top   = mem[sp - ONE];
  assign empty = (cnt == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      sp  <= '0;
      cnt <= '0;
    end else if (push) begin
      sp <= sp + ONE;
      if (cnt != FULL)
        cnt <= cnt + CNT1;
    end else if (pop && !empty) begin
      sp  <= sp - ONE;
      cnt <= cnt - CNT1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push)
      mem[sp] <= din;
  end

endmodule

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: PC register, next-PC mux, trap/eret and halt FSM.
// Ports: CLK, RST (sync, active-high), bus (pc_seq_unit_if.slave).
// Optional return stack enabled by `define PC_RAS_EN.
module pc_seq_unit
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [31:0]     EXC_VEC   = 32'h0000_0080,
  parameter int              RAS_DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST,
  pc_seq_unit_if.slave bus
);

  localparam logic [XLEN-1:0] EXC_T = XLEN'(EXC_VEC);
  localparam logic [XLEN-1:0] FOUR  = XLEN'(4);

  state_e          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] epc, epc_n;
  logic [1:0]      cause, cause_n;
  logic [XLEN-1:0] pc4, nxt, br_off;
  logic [XLEN-1:0] ras_tgt;
  logic            commit;

  assign pc4    = pc + FOUR;
  assign br_off = {bus.ImExt[XLEN-3:0], 2'b00};

`ifdef PC_RAS_EN
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            ras_push, ras_pop;

  assign ras_push = commit && (bus.PCSrc == PCSRC_JMP) && bus.link;
  assign ras_pop  = commit && (bus.PCSrc == PCSRC_RAS);
  // Empty stack falls back to the register-indirect target.
  assign ras_tgt  = ras_empty ? bus.ReadData1 : ras_top;

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK   (CLK),
    .RST   (RST),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc4),
    .top   (ras_top),
    .empty (ras_empty)
  );
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_link;

  assign unused_link = bus.link;
  assign ras_tgt     = pc4;
`endif

  always_comb begin
    nxt = pc4;
    case (bus.PCSrc)
      PCSRC_SEQ:  nxt = pc4;
      PCSRC_BR:   nxt = pc4 + br_off;
      PCSRC_REG:  nxt = bus.ReadData1;
      PCSRC_JMP:  nxt = {pc4[XLEN-1:28],
                         bus.j_addr, 2'b00};
      PCSRC_ERET: nxt = epc;
      PCSRC_RAS:  nxt = ras_tgt;
      default:    nxt = pc4;
    endcase
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    epc_n   = epc;
    cause_n = cause;
    commit  = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.exc_req) begin
          epc_n   = pc;
          cause_n = CAUSE_EXT;
          pc_n    = EXC_T;
          state_n = TRAP;
        end else if (bus.PCWre && nxt[1:0] != 2'b00) begin
          epc_n   = pc;
          cause_n = CAUSE_MISAL;
          pc_n    = EXC_T;
          state_n = TRAP;
        end else if (bus.PCWre) begin
          pc_n   = nxt;
          commit = 1'b1;
          if (bus.halt_req)
            state_n = HALT;
        end
      end
      TRAP:    state_n = RUN;
      HALT:    state_n = HALT;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      pc    <= RESET_VEC;
      epc   <= '0;
      cause <= CAUSE_NONE;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      epc   <= epc_n;
      cause <= cause_n;
    end
  end

  assign bus.currentPC = pc;
  assign bus.nextPC    = nxt;
  assign bus.epc       = epc;
  assign bus.cause     = cause;
  assign bus.trap      = (state == TRAP);
  assign bus.halted    = (state == HALT);

endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed vectors with a cycle-tagged
// expectation queue checked by an independent monitor.
module tb_pc_seq_unit;

  logic CLK;
  logic RST;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  typedef enum int {
    K_CUR, K_NXT, K_EPC, K_CAUSE, K_TRAP, K_HALT
  } kind_e;

  typedef struct {
    int          cyc;
    kind_e       k;
    logic [31:0] v;
  } exp_t;

  exp_t q[$];

  pc_seq_unit_if #(.XLEN(32)) bus ();

  pc_seq_unit #(
    .XLEN      (32),
    .RESET_VEC (32'h0),
    .EXC_VEC   (32'h80),
    .RAS_DEPTH (4)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc++;

  function automatic logic [31:0] got(input kind_e k);
    case (k)
      K_CUR:   return bus.currentPC;
      K_NXT:   return bus.nextPC;
      K_EPC:   return bus.epc;
      K_CAUSE: return {30'd0, bus.cause};
      K_TRAP:  return {31'd0, bus.trap};
      default: return {31'd0, bus.halted};
    endcase
  endfunction

  always @(negedge CLK) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        n_chk++;
        if (q[i].cyc < cyc || got(q[i].k) !== q[i].v) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got=%h exp=%h",
                   q[i].k.name(), q[i].cyc,
                   got(q[i].k), q[i].v);
        end
        q.delete(i);
      end
    end
  end

  task automatic expect_at(input int off, input kind_e k,
                           input logic [31:0] v);
    exp_t e;
    e.cyc = cyc + off;
    e.k   = k;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic w, input logic [2:0] s,
                       input logic [31:0] imm,
                       input logic [25:0] ja,
                       input logic [31:0] rd,
                       input logic l, input logic e,
                       input logic h);
    bus.PCWre     = w;
    bus.PCSrc     = s;
    bus.ImExt     = imm;
    bus.j_addr    = ja;
    bus.ReadData1 = rd;
    bus.link      = l;
    bus.exc_req   = e;
    bus.halt_req  = h;
  endtask

  initial begin
    RST = 1'b1;
    drive(0, 3'b000, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    expect_at(0, K_CUR, 32'h0);
    expect_at(0, K_EPC, 32'h0);
    expect_at(0, K_CAUSE, 32'h0);
    expect_at(0, K_TRAP, 32'h0);
    expect_at(0, K_HALT, 32'h0);
    tick();
    RST = 1'b0;

    drive(1, 3'b000, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      expect_at(0, K_NXT, 32'(4 * i));
      expect_at(1, K_CUR, 32'(4 * i));
      tick();
    end

    drive(1, 3'b010, 0, 0, 32'h100, 0, 0, 0);
    expect_at(1, K_CUR, 32'h100);
    tick();
    drive(1, 3'b001, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
    expect_at(0, K_NXT, 32'hFC);
    expect_at(1, K_CUR, 32'hFC);
    tick();

    drive(1, 3'b010, 0, 0, 32'h100, 0, 0, 0);
    tick();
    drive(1, 3'b010, 0, 0, 32'h202, 0, 0, 0);
    expect_at(0, K_NXT, 32'h202);
    expect_at(1, K_CUR, 32'h80);
    expect_at(1, K_EPC, 32'h100);
    expect_at(1, K_CAUSE, 32'h1);
    expect_at(1, K_TRAP, 32'h1);
    tick();
    drive(1, 3'b000, 0, 0, 0, 0, 1, 1);
    expect_at(1, K_CUR, 32'h80);
    expect_at(1, K_TRAP, 32'h0);
    expect_at(1, K_EPC, 32'h100);
    expect_at(1, K_CAUSE, 32'h1);
    expect_at(1, K_HALT, 32'h0);
    tick();
    drive(1, 3'b100, 0, 0, 0, 0, 0, 0);
    expect_at(0, K_NXT, 32'h100);
    expect_at(1, K_CUR, 32'h100);
    expect_at(1, K_CAUSE, 32'h1);
    tick();

    drive(1, 3'b010, 0, 0, 32'h40, 0, 0, 0);
    tick();
    drive(1, 3'b000, 0, 0, 0, 0, 1, 0);
    expect_at(1, K_CUR, 32'h80);
    expect_at(1, K_EPC, 32'h40);
    expect_at(1, K_CAUSE, 32'h2);
    expect_at(1, K_TRAP, 32'h1);
    tick();
    drive(0, 3'b000, 0, 0, 0, 0, 0, 0);
    expect_at(1, K_CUR, 32'h80);
    expect_at(1, K_TRAP, 32'h0);
    tick();
    expect_at(1, K_CUR, 32'h80);
    tick();

    drive(1, 3'b011, 0, 26'h8, 0, 0, 0, 0);
    expect_at(0, K_NXT, 32'h20);
    expect_at(1, K_CUR, 32'h20);
    tick();
    drive(0, 3'b110, 0, 0, 0, 0, 0, 0);
    expect_at(0, K_NXT, 32'h24);
    expect_at(1, K_CUR, 32'h20);
    tick();
    drive(1, 3'b000, 0, 0, 0, 0, 0, 1);
    expect_at(1, K_CUR, 32'h24);
    expect_at(1, K_HALT, 32'h1);
    tick();
    drive(1, 3'b000, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      expect_at(1, K_CUR, 32'h24);
      expect_at(1, K_HALT, 32'h1);
      expect_at(1, K_TRAP, 32'h0);
      tick();
    end
    RST = 1'b1;
    expect_at(1, K_CUR, 32'h0);
    expect_at(1, K_HALT, 32'h0);
    expect_at(1, K_EPC, 32'h0);
    expect_at(1, K_CAUSE, 32'h0);
    tick();
    RST = 1'b0;
    drive(0, 3'b000, 0, 0, 0, 0, 0, 0);

`ifdef PC_RAS_EN
    for (int n = 1; n <= 5; n++) begin
      drive(1, 3'b010, 0, 0, 32'(16 * n), 0, 0, 0);
      tick();
      drive(1, 3'b011, 0, 26'h100, 0, 1, 0, 0);
      expect_at(1, K_CUR, 32'h400);
      tick();
    end
    begin
      logic [31:0] tgt [5];
      tgt = '{32'h54, 32'h44, 32'h34, 32'h24, 32'h600};
      drive(1, 3'b101, 0, 0, 32'h600, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
        expect_at(0, K_NXT, tgt[i]);
        expect_at(1, K_CUR, tgt[i]);
        tick();
      end
    end
`else
    drive(1, 3'b101, 0, 0, 32'h600, 1, 0, 0);
    expect_at(0, K_NXT, 32'h4);
    expect_at(1, K_CUR, 32'h4);
    tick();
`endif

    drive(0, 3'b000, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got=%0d exp=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
